// File: rtl/sipo_router.sv
`timescale 1ns/1ps
// sipo_router
// Collects a serial bit stream into a frame and, on send, commits the frame
// to one of three parallel destinations (AES data, key, memory word), or
// serialises a memory word back out LSB first.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   en, data_i          serial bit strobe and bit
//   send                one-cycle commit / readback start
//   instruction         00 AES data, 01 key, 10 memory write, 11 readback
//   mem_data_i          memory word captured at readback start
//   aes_data_o/_valid   committed AES frame and its commit pulse
//   key_data_o/_valid   committed key and its commit pulse
//   mem_data_o/_valid   committed memory word and its commit pulse
//   data_o, data_o_valid readback serial bit and its qualifier
//   bit_count_o         bits collected in the current frame
//   err_o, busy_o       rejected-commit pulse; readback in progress
//
// state    | meaning
// COLLECT  | shifting serial bits into the frame, waiting for send
// READBACK | shifting the captured memory word out on data_o
module sipo_router #(
    parameter int FRAME_W = 128,
    parameter int MEM_W   = 32,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               send,
    input  logic [1:0]         instruction,
    input  logic               data_i,
    input  logic [MEM_W-1:0]   mem_data_i,
    output logic [FRAME_W-1:0] aes_data_o,
    output logic               aes_valid_o,
    output logic [FRAME_W-1:0] key_data_o,
    output logic               key_valid_o,
    output logic [MEM_W-1:0]   mem_data_o,
    output logic               mem_valid_o,
    output logic               data_o,
    output logic               data_o_valid,
    output logic [CNT_W-1:0]   bit_count_o,
    output logic               err_o,
    output logic               busy_o
);

    typedef enum logic {COLLECT, READBACK} state_t;

    localparam logic [CNT_W-1:0] LEN_FRAME = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] LEN_MEM   = CNT_W'(MEM_W);
    localparam logic [CNT_W-1:0] RB_LAST   = CNT_W'(MEM_W - 1);

    state_t             state;
    // Bits enter at the top and move down, so after L bits the first bit
    // sits at FRAME_W-L; a memory frame therefore lives in the top MEM_W bits.
    logic [FRAME_W-1:0] frame_sr;
    logic               overflow;
    logic [1:0]         last_instr;
    logic [MEM_W-1:0]   rb_sr;
    logic [CNT_W-1:0]   rb_left;
    logic [CNT_W-1:0]   frame_len;
    logic               frame_full;

    always_comb begin
        frame_len = LEN_FRAME;
        if (instruction == 2'b10) begin
            frame_len = LEN_MEM;
        end
    end

    assign frame_full = (bit_count_o == frame_len);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= COLLECT;
            frame_sr     <= '0;
            overflow     <= 1'b0;
            last_instr   <= 2'b00;
            rb_sr        <= '0;
            rb_left      <= '0;
            bit_count_o  <= '0;
            aes_data_o   <= '0;
            aes_valid_o  <= 1'b0;
            key_data_o   <= '0;
            key_valid_o  <= 1'b0;
            mem_data_o   <= '0;
            mem_valid_o  <= 1'b0;
            data_o       <= 1'b0;
            data_o_valid <= 1'b0;
            err_o        <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            aes_valid_o <= 1'b0;
            key_valid_o <= 1'b0;
            mem_valid_o <= 1'b0;
            err_o       <= 1'b0;
            last_instr  <= instruction;

            case (state)
                COLLECT: begin
                    if (instruction != last_instr && bit_count_o != '0) begin
                        // route switched mid-frame: drop the partial frame silently
                        bit_count_o <= '0;
                        overflow    <= 1'b0;
                    end else if (send) begin
                        bit_count_o <= '0;
                        overflow    <= 1'b0;
                        if (instruction == 2'b11) begin
                            state        <= READBACK;
                            busy_o       <= 1'b1;
                            data_o       <= mem_data_i[0];
                            data_o_valid <= 1'b1;
                            rb_sr        <= mem_data_i >> 1;
                            rb_left      <= RB_LAST;
                        end else if (frame_full && !overflow) begin
                            case (instruction)
                                2'b00: begin
                                    aes_data_o  <= frame_sr;
                                    aes_valid_o <= 1'b1;
                                end
                                2'b01: begin
                                    key_data_o  <= frame_sr;
                                    key_valid_o <= 1'b1;
                                end
                                default: begin
                                    mem_data_o  <= frame_sr[FRAME_W-1 -: MEM_W];
                                    mem_valid_o <= 1'b1;
                                end
                            endcase
                        end else begin
                            err_o <= 1'b1;
                        end
                    end else if (en && instruction != 2'b11) begin
                        if (bit_count_o < frame_len) begin
                            frame_sr    <= {data_i, frame_sr[FRAME_W-1:1]};
                            bit_count_o <= bit_count_o + 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end

                READBACK: begin
                    if (rb_left == '0) begin
                        state        <= COLLECT;
                        busy_o       <= 1'b0;
                        data_o       <= 1'b0;
                        data_o_valid <= 1'b0;
                    end else begin
                        data_o  <= rb_sr[0];
                        rb_sr   <= rb_sr >> 1;
                        rb_left <= rb_left - 1'b1;
                    end
                end

                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_router.sv
`timescale 1ns/1ps
module tb_sipo_router;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         send;
    logic [1:0]   instruction;
    logic         data_i;
    logic [31:0]  mem_data_i;
    logic [127:0] aes_data_o;
    logic         aes_valid_o;
    logic [127:0] key_data_o;
    logic         key_valid_o;
    logic [31:0]  mem_data_o;
    logic         mem_valid_o;
    logic         data_o;
    logic         data_o_valid;
    logic [7:0]   bit_count_o;
    logic         err_o;
    logic         busy_o;

    int vectors = 0;
    int miscompares = 0;

    sipo_router dut (
        .clk(clk), .rst(rst), .en(en), .send(send), .instruction(instruction),
        .data_i(data_i), .mem_data_i(mem_data_i),
        .aes_data_o(aes_data_o), .aes_valid_o(aes_valid_o),
        .key_data_o(key_data_o), .key_valid_o(key_valid_o),
        .mem_data_o(mem_data_o), .mem_valid_o(mem_valid_o),
        .data_o(data_o), .data_o_valid(data_o_valid),
        .bit_count_o(bit_count_o), .err_o(err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // inputs change on the falling edge, DUT samples on the rising edge
    task automatic shift_bits(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            en = 1'b1;
            data_i = v[i];
            @(negedge clk);
        end
        en = 1'b0;
        data_i = 1'b0;
    endtask

    task automatic pulse_send();
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    localparam logic [127:0] AES_A = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [127:0] KEY_A = 128'hfedcba9876543210_0f1e2d3c4b5a6978;
    localparam logic [127:0] AES_B = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] AES_C = 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
    localparam logic [127:0] AES_D = 128'h13579bdf_2468ace0_fedcba98_01234567;

    initial begin
        logic [31:0] rb_word;
        rst = 1'b0; en = 1'b0; send = 1'b0; instruction = 2'b00;
        data_i = 1'b0; mem_data_i = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_aes", aes_data_o, '0);
        check("rst_key", key_data_o, '0);
        check("rst_mem", {96'b0, mem_data_o}, '0);
        check("rst_cnt", {120'b0, bit_count_o}, '0);
        check("rst_busy", {127'b0, busy_o}, '0);
        check("rst_dout", {126'b0, data_o, data_o_valid}, '0);
        rst = 1'b1;
        @(negedge clk);

        // AES frame commit
        instruction = 2'b00;
        shift_bits(AES_A, 128);
        check("aes_cnt128", {120'b0, bit_count_o}, 128);
        pulse_send();
        check("aes_valid", {127'b0, aes_valid_o}, 1);
        check("aes_data", aes_data_o, AES_A);
        check("aes_key0", key_data_o, '0);
        check("aes_err", {127'b0, err_o}, 0);
        @(negedge clk);
        check("aes_valid_drop", {127'b0, aes_valid_o}, 0);
        check("aes_cnt_clr", {120'b0, bit_count_o}, 0);

        // key commit, then over-long key frame rejected
        instruction = 2'b01;
        shift_bits(KEY_A, 128);
        pulse_send();
        check("key_valid", {127'b0, key_valid_o}, 1);
        check("key_data", key_data_o, KEY_A);
        check("key_aes_hold", aes_data_o, AES_A);
        shift_bits(AES_B, 128);
        shift_bits(128'h3, 2);
        check("key_ovf_cnt", {120'b0, bit_count_o}, 128);
        pulse_send();
        check("key_ovf_err", {127'b0, err_o}, 1);
        check("key_ovf_valid", {127'b0, key_valid_o}, 0);
        check("key_ovf_hold", key_data_o, KEY_A);
        check("key_ovf_cnt0", {120'b0, bit_count_o}, 0);
        @(negedge clk);
        check("key_err_drop", {127'b0, err_o}, 0);

        // memory word commit, then short word rejected
        instruction = 2'b10;
        shift_bits(128'hdeadbeef, 32);
        pulse_send();
        check("mem_valid", {127'b0, mem_valid_o}, 1);
        check("mem_data", {96'b0, mem_data_o}, 128'hdeadbeef);
        check("mem_err", {127'b0, err_o}, 0);
        shift_bits(128'h12345678, 31);
        pulse_send();
        check("mem_short_err", {127'b0, err_o}, 1);
        check("mem_short_valid", {127'b0, mem_valid_o}, 0);
        check("mem_short_hold", {96'b0, mem_data_o}, 128'hdeadbeef);

        // route change mid-frame aborts silently
        instruction = 2'b00;
        @(negedge clk);
        shift_bits(128'h3ff, 10);
        check("abort_cnt10", {120'b0, bit_count_o}, 10);
        instruction = 2'b01;
        @(negedge clk);
        check("abort_cnt0", {120'b0, bit_count_o}, 0);
        check("abort_err", {127'b0, err_o}, 0);
        check("abort_aes_hold", aes_data_o, AES_A);

        // readback of a memory word, with noise on the inputs meanwhile
        rb_word = 32'h80000001;
        mem_data_i = rb_word;
        instruction = 2'b11;
        @(negedge clk);
        pulse_send();
        for (int i = 0; i < 32; i++) begin
            check("rb_busy", {127'b0, busy_o}, 1);
            check("rb_valid", {127'b0, data_o_valid}, 1);
            check("rb_bit", {127'b0, data_o}, {127'b0, rb_word[i]});
            check("rb_err", {127'b0, err_o}, 0);
            en = (i < 30) ? i[0] : 1'b0;
            send = (i < 30) ? ~i[0] : 1'b0;
            data_i = 1'b1;
            instruction = i[1] ? 2'b00 : 2'b10;
            if (i == 5) mem_data_i = 32'h0;
            @(negedge clk);
        end
        check("rb_busy_end", {127'b0, busy_o}, 0);
        check("rb_valid_end", {127'b0, data_o_valid}, 0);
        check("rb_dout_end", {127'b0, data_o}, 0);
        check("rb_cnt_after", {120'b0, bit_count_o}, 0);
        check("rb_mem_hold", {96'b0, mem_data_o}, 128'hdeadbeef);
        check("rb_aes_hold", aes_data_o, AES_A);
        data_i = 1'b0;

        // asynchronous reset mid-frame
        instruction = 2'b00;
        @(negedge clk);
        shift_bits(AES_B, 64);
        check("pre_rst_cnt", {120'b0, bit_count_o}, 64);
        rst = 1'b0;
        #1;
        check("arst_aes", aes_data_o, '0);
        check("arst_key", key_data_o, '0);
        check("arst_mem", {96'b0, mem_data_o}, '0);
        check("arst_cnt", {120'b0, bit_count_o}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        shift_bits(AES_C, 128);
        pulse_send();
        check("post_rst_valid", {127'b0, aes_valid_o}, 1);
        check("post_rst_aes", aes_data_o, AES_C);

        // en and send together on a full frame: send wins, bit dropped
        shift_bits(AES_B, 128);
        en = 1'b1;
        data_i = 1'b1;
        pulse_send();
        en = 1'b0;
        data_i = 1'b0;
        check("dual_valid", {127'b0, aes_valid_o}, 1);
        check("dual_aes", aes_data_o, AES_B);
        check("dual_cnt0", {120'b0, bit_count_o}, 0);
        shift_bits(AES_D, 128);
        pulse_send();
        check("dual_next_valid", {127'b0, aes_valid_o}, 1);
        check("dual_next_aes", aes_data_o, AES_D);
        check("dual_next_err", {127'b0, err_o}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
